// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_e;
   typedef logic port_t;
   localparam logic [15:0] ADDR_LAST = 16'hFFFF;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin / fixed-priority picker with last-grant pointer
module rr_arb2
   import dmem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   input  logic       fixed,
   output logic [1:0] gnt
);
   port_t ptr_q, ptr_d, win;
   // on a tie, round-robin picks the port that did not win last
   always_comb begin
      win   = req[1] & (~req[0] | (~fixed & ~ptr_q));
      gnt   = en ? {win, req[0] & ~win} : 2'b00;
      ptr_d = (|gnt) ? win : ptr_q;
   end
   always_ff @(posedge clk) ptr_q <= reset ? 1'b1 : ptr_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the single-ported data memory,
// with a fixed two-cycle read return and rejection of the wrapping address.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0,
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   output logic          err0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          err1,
   output logic          mem_we,
   output logic          mem_re,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   localparam logic [AW-1:0] LAST = AW'(ADDR_LAST);
   state_e        state_q, state_d;
   port_t         owner_q, owner_d, win;
   logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d, sel_wdata;
   logic [AW-1:0] sel_addr;
   logic [1:0]    gnt;
   logic          can_cmd, any, sel_we, bad;

   assign can_cmd = ~reset & (state_q == IDLE | state_q == RD_DONE);

   rr_arb2 u_arb (
      .clk  (clk),
      .reset(reset),
      .req  ({req1, req0}),
      .en   (can_cmd),
      .fixed(FIXED_PRIO),
      .gnt  (gnt)
   );

   always_comb begin
      win       = gnt[1];
      any       = |gnt;
      sel_we    = win ? we1 : we0;
      sel_addr  = win ? addr1 : addr0;
      sel_wdata = win ? wdata1 : wdata0;
      bad       = sel_addr == LAST;
      gnt0      = gnt[0];
      gnt1      = gnt[1];
      err0      = gnt[0] & bad;
      err1      = gnt[1] & bad;
      mem_we    = any & ~bad & sel_we;
      mem_re    = any & ~bad & ~sel_we;
      mem_addr  = any ? sel_addr : '0;
      mem_wdata = any ? sel_wdata : '0;
      // a reset cycle discards the read in flight
      rvalid0   = ~reset & (state_q == RD_DONE) & ~owner_q;
      rvalid1   = ~reset & (state_q == RD_DONE) & owner_q;
      state_d   = mem_re ? RD_WAIT : (state_q == RD_WAIT) ? RD_DONE : IDLE;
      owner_d   = mem_re ? win : owner_q;
      rdata0_d  = (state_q == RD_WAIT & ~owner_q) ? mem_rdata : rdata0_q;
      rdata1_d  = (state_q == RD_WAIT & owner_q) ? mem_rdata : rdata1_q;
      rdata0    = rdata0_q;
      rdata1    = rdata1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: round-robin and fixed-priority arbiters on shared request
// traffic, each with its own byte memory and a cycle-level reference model.
module tb_dmem_arbiter;
   logic        clk = 1'b0, reset = 1'b1;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(int i);
      return i == 0 ? 8'hCD : i == 1 ? 8'h2B : 8'(i ^ (i >> 8) ^ 32'h5A);
   endfunction

   function automatic logic [15:0] rnd_addr();
      int r;
      r = $urandom_range(0, 15);
      return r == 0 ? 16'hFFFF : r == 1 ? 16'hFFFE : 16'($urandom_range(0, 31));
   endfunction

   task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d got %h want %h", nm, k, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1, mem_we, mem_re;
      logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
      logic [7:0]  env [65536];
      logic [7:0]  ref_mem [65536];

      dmem_arbiter #(.FIXED_PRIO(1'(g)), .AW(16), .DW(16)) u_dut (
         .clk(clk), .reset(reset),
         .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
         .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
         .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
         .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
         .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
         .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
      );

      initial for (int i = 0; i < 65536; i++) env[i] <= init_byte(i);

      // byte-addressed little-endian memory, one-cycle read
      always @(posedge clk) begin
         if (mem_we) begin
            env[mem_addr]         <= mem_wdata[7:0];
            env[mem_addr + 16'd1] <= mem_wdata[15:8];
         end
         if (mem_re) mem_rdata <= {env[mem_addr + 16'd1], env[mem_addr]};
      end

      initial begin : model
         int          cyc, free_at, due;
         logic        ptr, pend, pport, due_now, w, wr, chk_a, chk_w;
         logic [7:0]  e_ctl;
         logic [15:0] a, d, e_addr, e_wd, pdata;
         logic [15:0] exp_rd [2];
         for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
         cyc = 0; free_at = 0; due = 0; ptr = 1'b1; pend = 1'b0; pport = 1'b0; pdata = '0;
         exp_rd[0] = '0; exp_rd[1] = '0;
         forever begin
            @(negedge clk);
            e_ctl = '0; e_addr = '0; e_wd = '0; chk_a = 1'b0; chk_w = 1'b0;
            due_now = pend && due == cyc;
            if (due_now) begin
               exp_rd[pport] = pdata;
               pend = 1'b0;
            end
            if (!reset) begin
               if (due_now) e_ctl[pport ? 3 : 2] = 1'b1;
               if (cyc >= free_at && (req0 || req1)) begin
                  w = (req0 && req1) ? (g == 1 ? 1'b0 : !ptr) : req1;
                  ptr = w;
                  a = w ? addr1 : addr0;
                  d = w ? wdata1 : wdata0;
                  wr = w ? we1 : we0;
                  e_ctl[w ? 7 : 6] = 1'b1;
                  if (a == 16'hFFFF) e_ctl[w ? 5 : 4] = 1'b1;
                  else if (wr) begin
                     e_ctl[1] = 1'b1; e_addr = a; e_wd = d; chk_a = 1'b1; chk_w = 1'b1;
                     ref_mem[a] = d[7:0];
                     ref_mem[a + 16'd1] = d[15:8];
                  end else begin
                     e_ctl[0] = 1'b1; e_addr = a; chk_a = 1'b1;
                     pend = 1'b1; pport = w; due = cyc + 2; free_at = cyc + 2;
                     pdata = {ref_mem[a + 16'd1], ref_mem[a]};
                  end
               end
            end
            chk("ctl", g, {8'h0, gnt1, gnt0, err1, err0, rvalid1, rvalid0, mem_we, mem_re}, {8'h0, e_ctl});
            chk("rdata0", g, rdata0, exp_rd[0]);
            chk("rdata1", g, rdata1, exp_rd[1]);
            chk("we_and_re", g, {15'h0, mem_we & mem_re}, 16'h0);
            if (chk_a) chk("mem_addr", g, mem_addr, e_addr);
            if (chk_w) chk("mem_wdata", g, mem_wdata, e_wd);
            if (reset) begin
               pend = 1'b0; ptr = 1'b1; free_at = cyc + 1;
               exp_rd[0] = '0; exp_rd[1] = '0;
            end
            cyc++;
         end
      end
   end

   task automatic step(input logic rs, input logic r0, input logic w0, input logic [15:0] a0,
                       input logic [15:0] d0, input logic r1, input logic w1,
                       input logic [15:0] a1, input logic [15:0] d1);
      @(posedge clk);
      #1;
      reset = rs; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   initial begin
      logic [5:0]  p00, p01, p10, p11;
      logic        r0, w0, r1, w1;
      logic [15:0] a0, d0, a1, d1;
      p00 = '0; p01 = '0; p10 = '0; p11 = '0;
      r0 = 0; w0 = 0; r1 = 0; w1 = 0; a0 = '0; d0 = '0; a1 = '0; d1 = '0;
      step(1, 0, 0, '0, '0, 0, 0, '0, '0);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0);
      idle();
      chk("lit_rst_rdata0", 0, g_dut[0].rdata0, 16'h0);
      chk("lit_rst_ctl", 1, {13'h0, g_dut[1].gnt0, g_dut[1].mem_re, g_dut[1].rvalid0}, 16'h0);

      step(0, 1, 0, 16'h0000, '0, 0, 0, '0, '0);
      chk("lit_rd_cmd", 0, {13'h0, g_dut[0].gnt0, g_dut[0].mem_re, g_dut[0].mem_we}, 16'h6);
      chk("lit_rd_addr", 0, g_dut[0].mem_addr, 16'h0000);
      idle();
      chk("lit_rd_wait", 0, {13'h0, g_dut[0].gnt0, g_dut[0].mem_re, g_dut[0].rvalid0}, 16'h0);
      idle();
      chk("lit_rd_valid", 0, {15'h0, g_dut[0].rvalid0}, 16'h1);
      chk("lit_rd_data", 0, g_dut[0].rdata0, 16'h2BCD);

      step(0, 0, 0, '0, '0, 1, 1, 16'h0010, 16'hBEEF);
      chk("lit_wr_cmd", 0, {13'h0, g_dut[0].gnt1, g_dut[0].mem_we, g_dut[0].mem_re}, 16'h6);
      chk("lit_wr_data", 0, g_dut[0].mem_wdata, 16'hBEEF);
      step(0, 0, 0, '0, '0, 1, 0, 16'h0010, '0);
      chk("lit_rd1_cmd", 0, {14'h0, g_dut[0].gnt1, g_dut[0].mem_re}, 16'h3);
      idle();
      idle();
      chk("lit_rd1_valid", 0, {14'h0, g_dut[0].rvalid1, g_dut[0].rvalid0}, 16'h2);
      chk("lit_rd1_data", 0, g_dut[0].rdata1, 16'hBEEF);

      for (int t = 0; t < 6; t++) begin
         step(0, 1, 0, 16'h0002, '0, 1, 0, 16'h0004, '0);
         p00[t] = g_dut[0].gnt0; p01[t] = g_dut[0].gnt1;
         p10[t] = g_dut[1].gnt0; p11[t] = g_dut[1].gnt1;
      end
      chk("lit_rr_gnt0", 0, {10'h0, p00}, 16'b010001);
      chk("lit_rr_gnt1", 0, {10'h0, p01}, 16'b000100);
      chk("lit_fp_gnt0", 1, {10'h0, p10}, 16'b010101);
      chk("lit_fp_gnt1", 1, {10'h0, p11}, 16'h0);
      idle();
      idle();

      step(0, 1, 1, 16'hFFFF, 16'h1234, 0, 0, '0, '0);
      chk("lit_ffff", 0, {12'h0, g_dut[0].gnt0, g_dut[0].err0, g_dut[0].mem_we, g_dut[0].mem_re}, 16'hC);
      chk("lit_ffff", 1, {12'h0, g_dut[1].gnt0, g_dut[1].err0, g_dut[1].mem_we, g_dut[1].mem_re}, 16'hC);
      step(0, 1, 0, 16'hFFFE, '0, 0, 0, '0, '0);
      idle();
      idle();
      chk("lit_ffff_kept", 0, g_dut[0].rdata0, 16'h5A5B);

      step(0, 0, 0, '0, '0, 1, 0, 16'h0020, '0);
      chk("lit_abort_gnt", 0, {15'h0, g_dut[0].gnt1}, 16'h1);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0);
      idle();
      for (int k = 0; k < 2; k++) begin
         chk("lit_abort_ctl", k, k == 0 ?
             {8'h0, g_dut[0].gnt1, g_dut[0].gnt0, g_dut[0].err1, g_dut[0].err0,
              g_dut[0].rvalid1, g_dut[0].rvalid0, g_dut[0].mem_we, g_dut[0].mem_re} :
             {8'h0, g_dut[1].gnt1, g_dut[1].gnt0, g_dut[1].err1, g_dut[1].err0,
              g_dut[1].rvalid1, g_dut[1].rvalid0, g_dut[1].mem_we, g_dut[1].mem_re}, 16'h0);
         chk("lit_abort_rdata1", k, k == 0 ? g_dut[0].rdata1 : g_dut[1].rdata1, 16'h0);
      end
      repeat (3) idle();

      for (int n = 0; n < 10000; n++) begin
         if (!(r0 && !g_dut[0].gnt0 && $urandom_range(0, 3) != 0)) begin
            r0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
            a0 = rnd_addr(); d0 = 16'($urandom);
         end
         if (!(r1 && !g_dut[0].gnt1 && $urandom_range(0, 3) != 0)) begin
            r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            a1 = rnd_addr(); d1 = 16'($urandom);
         end
         step($urandom_range(0, 299) == 0, r0, w0, a0, d0, r1, w1, a1, d1);
      end
      repeat (4) idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-ported 16-bit data memory. Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader. The block grants one request at a time and drives the memory's read/write enables, address and write data. It returns read data with fixed latency and never lets read_enable and write_enable be high together.

Parameters:
FIXED_PRIO, 0, 1 = port 0 always wins contention; 0 = round-robin between ports
AW, 16, address width (byte address)
DW, 16, data width

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  AW  port 0 byte address
wdata0  in  DW  port 0 write data
gnt0  out  1  port 0 accept pulse, one cycle
rvalid0  out  1  port 0 read data valid, one cycle
rdata0  out  DW  port 0 read data
err0  out  1  port 0 rejected-access pulse, one cycle
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1  same as port 0, for port 1
mem_we  out  1  memory write_enable
mem_re  out  1  memory read_enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory data_in
mem_rdata  in  DW  memory data_out; valid the cycle after mem_re is sampled

Behaviour:
- Reset (sync): state=IDLE; all gnt/rvalid/err/mem_we/mem_re = 0; rdata/mem_addr/mem_wdata = 0; last-grant pointer = 1, so port 0 wins the first tie.
- FSM states are IDLE, RD_WAIT and RD_DONE.
- IDLE: choose a winner from the pending requests.
  - Exactly one pending: that port wins.
  - Both pending, FIXED_PRIO=1: port 0 wins.
  - Both pending, FIXED_PRIO=0: the port not in the pointer wins.
  - Pointer updates on every grant.
  - The winner's gnt is a combinational pulse in the command cycle T. mem_addr/mem_wdata/mem_we/mem_re are driven from the winner's inputs in T.
- Write: mem_we=1 for cycle T only; stay IDLE. Back-to-back writes are allowed, one per cycle.
- Read: mem_re=1 in T, then go to RD_WAIT.
  - RD_WAIT (T+1): no command, all gnt=0. Register mem_rdata into rdataN of the owning port, then go to RD_DONE.
  - RD_DONE (T+2): rvalidN=1 for one cycle; arbitration resumes in this same cycle, as in IDLE.
  - Fixed latency: gnt to rvalid = 2 cycles. At most one read outstanding.
- rdataN holds its value until the next read for that port. The non-owning port's rdata is unchanged.
- Requester must hold req until gnt. Deasserting req before gnt withdraws the request; no error.
- Address rule: addr = 16'hFFFF is rejected, because the upper byte would wrap.
  - Rejection: errN pulses in the grant cycle together with gntN.
  - No mem_we/mem_re; no rvalid; the FSM stays IDLE.
  - A rejection still counts as a grant for the round-robin pointer.
- Odd addresses other than FFFF are legal and passed through unchanged.
- Invariant: mem_we & mem_re == 0 in every cycle. A mem command is issued only in IDLE or RD_DONE.
- Reset during RD_WAIT/RD_DONE: the read is discarded and no rvalid is issued in or after the reset cycle.
- Simultaneous rvalid0 for a finished read and gnt1 for a new request in RD_DONE is legal.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum {IDLE, RD_WAIT, RD_DONE}
  - constant ADDR_LAST = 16'hFFFF
  - port index typedef (1 bit)
- One natural sub-module, rr_arb2: a two-input round-robin/fixed-priority picker with its pointer register. Inputs are req[1:0], en and fixed; outputs are a one-hot grant. The FSM, mux and return path stay in the top.

Test Plan:
- Reset, then port 0 reads addr 16'h0000 (memory reset image CD/2B) -> gnt0 in T, mem_re=1 in T only, rvalid0 in T+2 with rdata0 = 16'h2BCD.
- Port 1 writes 16'hBEEF to addr 16'h0010, then port 1 reads 16'h0010 -> write in one cycle with mem_we=1 and mem_wdata=16'hBEEF; read returns rvalid1 with 16'hBEEF; rvalid0 stays 0.
- Both ports hold read requests for 6 cycles, FIXED_PRIO=0 -> grants alternate 0,1,0,…, each 2 cycles apart via RD_DONE. With FIXED_PRIO=1, only port 0 is granted.
- Port 0 writes to addr 16'hFFFF -> gnt0 and err0 in the same cycle, mem_we stays 0, and memory at 16'hFFFF is unchanged.
- Port 1 read granted, then reset asserted in T+1 -> no rvalid1 ever appears and all outputs are 0 the next cycle.
- Random traffic on both ports for 10k cycles -> mem_we & mem_re never both 1; every accepted read produces exactly one rvalid to the correct port, with data matching a scoreboard.
